note_lane: RTL and testbench

//  Parametrised single-lane note dropper for the rhythm game: spawns NUM_NOTES arrows at fixed

---
 rtl/note_lane_if.sv | 29 ++
 rtl/note_lane.sv | 157 +++++++++++++++
 tb/tb_note_lane.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_lane_if.sv
// Key inputs and render/score outputs of one note lane.
// Outputs are registered in the lane; the interface itself adds no latency.
// No backpressure: keys are sampled every frame and outputs are always valid.
interface note_lane_if #(
   parameter int NUM_NOTES = 4
);
   logic [7:0]              keycode;
   logic [7:0]              keycode_second;
   logic [9:0]              laneX;
   logic [10*NUM_NOTES-1:0] noteY;
   logic [NUM_NOTES-1:0]    note_active;
   logic                    hit_pulse;
   logic                    miss_pulse;
   logic [7:0]              hit_count;
   logic [7:0]              miss_count;
   logic                    lane_done;

   modport master (
      input  keycode, keycode_second,
      output laneX, noteY, note_active, hit_pulse, miss_pulse,
             hit_count, miss_count, lane_done
   );

   modport slave (
      output keycode, keycode_second,
      input  laneX, noteY, note_active, hit_pulse, miss_pulse,
             hit_count, miss_count, lane_done
   );
endinterface

// File: rtl/note_lane.sv
// Single-lane note dropper: spawns, drops and grades notes on key presses.
// Latency: all outputs registered, a key press is graded one frame after it is seen.
// No backpressure: one update per frame_clk edge, inputs sampled unconditionally.
module note_lane #(
   parameter int           NUM_NOTES   = 4,
   parameter int           FIRST_SPAWN = 1500,
   parameter int           SPAWN_GAP   = 120,
   parameter int           X_POS       = 440,
   parameter int           Y_START     = 100,
   parameter int           NOTE_H      = 40,
   parameter int           HIT_LO      = 340,
   parameter int           Y_MAX       = 400,
   parameter int           SPEED       = 1,
   parameter logic [7:0]   KEY         = 8'h52,
   parameter logic [7:0]   START_KEY   = 8'h2c,
   parameter logic [7:0]   RESTART_KEY = 8'h01
) (
   input  logic         frame_clk,
   input  logic         Reset,
   note_lane_if.master  lane
);
   localparam logic [15:0] LAST_SPAWN = 16'(FIRST_SPAWN + (NUM_NOTES - 1) * SPAWN_GAP);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state_q, state_d;
   logic [15:0]                 cnt_q, cnt_d;
   logic [NUM_NOTES-1:0][9:0]   y_q, y_d;
   logic [NUM_NOTES-1:0]        active_q, active_d;
   logic [NUM_NOTES-1:0]        spawned_q, spawned_d;
   logic                        hit_pulse_q, hit_pulse_d;
   logic                        miss_pulse_q, miss_pulse_d;
   logic [7:0]                  hit_cnt_q, hit_cnt_d;
   logic [7:0]                  miss_cnt_q, miss_cnt_d;
   logic                        key_prev_q;

   logic                        key_now;
   logic                        press;
   logic [NUM_NOTES-1:0][9:0]   bottom;
   logic [NUM_NOTES-1:0]        at_miss;
   logic [NUM_NOTES-1:0]        in_win;
   logic                        graded;
   logic [4:0]                  n_miss;
   logic [8:0]                  miss_sum;

   assign key_now = (lane.keycode == KEY) | (lane.keycode_second == KEY);
   assign press   = key_now & ~key_prev_q;

   always_comb begin
      bottom  = '0;
      at_miss = '0;
      in_win  = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         bottom[i]  = y_q[i] + 10'(NOTE_H);
         at_miss[i] = active_q[i] && (bottom[i] >= 10'(Y_MAX));
         in_win[i]  = active_q[i] && (bottom[i] >= 10'(HIT_LO)) && (bottom[i] < 10'(Y_MAX));
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      y_d          = y_q;
      active_d     = active_q;
      spawned_d    = spawned_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      graded       = 1'b0;
      n_miss       = '0;
      miss_sum     = '0;
      case (state_q)
         IDLE: begin
            if (lane.keycode == START_KEY) begin
               state_d    = RUN;
               cnt_d      = '0;
               hit_cnt_d  = '0;
               miss_cnt_d = '0;
               active_d   = '0;
               spawned_d  = '0;
               y_d        = {NUM_NOTES{10'(Y_START)}};
            end
         end
         RUN: begin
            if (cnt_q != LAST_SPAWN) cnt_d = cnt_q + 16'd1;
            // Slot order gives the lowest-index in-window note priority on a press.
            for (int i = 0; i < NUM_NOTES; i++) begin
               if (active_q[i]) begin
                  if (at_miss[i]) begin
                     active_d[i] = 1'b0;
                     n_miss      = n_miss + 5'd1;
                  end else if (press && in_win[i] && !graded) begin
                     active_d[i] = 1'b0;
                     graded      = 1'b1;
                  end else begin
                     y_d[i] = y_q[i] + 10'(SPEED);
                  end
               end else if (!spawned_q[i] && (cnt_q == 16'(FIRST_SPAWN + i * SPAWN_GAP))) begin
                  active_d[i]  = 1'b1;
                  spawned_d[i] = 1'b1;
                  y_d[i]       = 10'(Y_START);
               end
            end
            if (graded) begin
               hit_pulse_d = 1'b1;
               if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
            end
            if (n_miss != 5'd0) begin
               miss_pulse_d = 1'b1;
               miss_sum     = {1'b0, miss_cnt_q} + {4'b0, n_miss};
               miss_cnt_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            end
            if ((&spawned_q) && !(|active_q)) state_d = DONE;
         end
         DONE: begin
            if (lane.keycode == RESTART_KEY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         y_q          <= {NUM_NOTES{10'(Y_START)}};
         active_q     <= '0;
         spawned_q    <= '0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         key_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         y_q          <= y_d;
         active_q     <= active_d;
         spawned_q    <= spawned_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         key_prev_q   <= key_now;
      end
   end

   assign lane.laneX       = 10'(X_POS);
   assign lane.noteY       = y_q;
   assign lane.note_active = active_q;
   assign lane.hit_pulse   = hit_pulse_q;
   assign lane.miss_pulse  = miss_pulse_q;
   assign lane.hit_count   = hit_cnt_q;
   assign lane.miss_count  = miss_cnt_q;
   assign lane.lane_done   = (state_q == DONE);
endmodule

// File: tb/tb_note_lane.sv
// Scoreboarded bench for note_lane: lane A (gap 10, speed 1) and lane B (gap 1, speed 2).
module tb_note_lane;
   localparam logic [7:0] KEY = 8'h52, START = 8'h2c, RESTART = 8'h01;

   logic frame_clk = 1'b0;
   logic Reset;
   int   fr = 0;

   always #5 frame_clk = ~frame_clk;
   always @(posedge frame_clk) fr <= fr + 1;

   note_lane_if #(.NUM_NOTES(2)) ifa();
   note_lane_if #(.NUM_NOTES(2)) ifb();

   note_lane #(.NUM_NOTES(2), .FIRST_SPAWN(4), .SPAWN_GAP(10), .SPEED(1)) dut_a (
      .frame_clk(frame_clk), .Reset(Reset), .lane(ifa)
   );
   note_lane #(.NUM_NOTES(2), .FIRST_SPAWN(4), .SPAWN_GAP(1), .SPEED(2)) dut_b (
      .frame_clk(frame_clk), .Reset(Reset), .lane(ifb)
   );

   typedef struct {
      bit hit;
      bit miss;
      int hc;
      int mc;
      int at;
   } ev_t;

   ev_t qa[$];
   ev_t qb[$];
   ev_t ea, eb;
   int  n_checks = 0;
   int  n_err    = 0;
   int  f0, g;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (frame %0d)", name, act, exp, fr);
      end
   endtask

   function automatic ev_t mk(input bit h, input bit m, input int hc, input int mc, input int at);
      ev_t e;
      e.hit = h; e.miss = m; e.hc = hc; e.mc = mc; e.at = at;
      return e;
   endfunction

   // Monitors: every pulse must match the oldest expected event of its lane.
   always @(negedge frame_clk) begin
      if (ifa.hit_pulse === 1'b1 || ifa.miss_pulse === 1'b1) begin
         if (qa.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL A unexpected pulse: hit=%0b miss=%0b frame %0d", ifa.hit_pulse, ifa.miss_pulse, fr);
         end else begin
            ea = qa.pop_front();
            chk("A pulse kind", {30'd0, ifa.hit_pulse, ifa.miss_pulse}, {30'd0, ea.hit, ea.miss});
            chk("A hit_count at pulse", ifa.hit_count, ea.hc);
            chk("A miss_count at pulse", ifa.miss_count, ea.mc);
            if (ea.at >= 0) chk("A pulse frame", fr, ea.at);
         end
      end
   end

   always @(negedge frame_clk) begin
      if (ifb.hit_pulse === 1'b1 || ifb.miss_pulse === 1'b1) begin
         if (qb.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL B unexpected pulse: hit=%0b miss=%0b frame %0d", ifb.hit_pulse, ifb.miss_pulse, fr);
         end else begin
            eb = qb.pop_front();
            chk("B pulse kind", {30'd0, ifb.hit_pulse, ifb.miss_pulse}, {30'd0, eb.hit, eb.miss});
            chk("B hit_count at pulse", ifb.hit_count, eb.hc);
            chk("B miss_count at pulse", ifb.miss_count, eb.mc);
            if (eb.at >= 0) chk("B pulse frame", fr, eb.at);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge frame_clk);
   endtask

   function automatic logic [9:0] ycur(input bit b, input int s);
      return b ? ifb.noteY[s*10 +: 10] : ifa.noteY[s*10 +: 10];
   endfunction

   task automatic wait_y(input bit b, input int s, input int val, input int budget);
      int k = 0;
      while (ycur(b, s) != 10'(val) && k < budget) begin
         step(1);
         k++;
      end
      chk($sformatf("wait lane%0d slot%0d y=%0d reached", b, s, val), {31'd0, ycur(b, s) == 10'(val)}, 1);
   endtask

   task automatic wait_done(input bit b, input int budget);
      int k = 0;
      while ((b ? ifb.lane_done : ifa.lane_done) !== 1'b1 && k < budget) begin
         step(1);
         k++;
      end
      chk($sformatf("wait lane%0d done", b), {31'd0, b ? ifb.lane_done : ifa.lane_done}, 1);
   endtask

   task automatic wait_active_a(input logic [1:0] val, input int budget);
      int k = 0;
      while (ifa.note_active !== val && k < budget) begin
         step(1);
         k++;
      end
      chk("wait A note_active", ifa.note_active, val);
   endtask

   task automatic restart_start_a();
      ifa.keycode = RESTART; step(1);
      ifa.keycode = START;   step(1);
      ifa.keycode = 8'h00;
   endtask

   initial begin
      Reset = 1'b1;
      ifa.keycode = 8'h00; ifa.keycode_second = 8'h00;
      ifb.keycode = 8'h00; ifb.keycode_second = 8'h00;
      step(2);
      Reset = 1'b0;

      // Reset state
      chk("rst lane_done", ifa.lane_done, 0);
      chk("rst note_active", ifa.note_active, 0);
      chk("rst hit_count", ifa.hit_count, 0);
      chk("rst miss_count", ifa.miss_count, 0);
      chk("rst noteY", ifa.noteY, {10'd100, 10'd100});
      chk("laneX", ifa.laneX, 440);

      // No key: both notes fall through and miss at bottom 400
      f0 = fr;
      qa.push_back(mk(0, 1, 0, 1, f0 + 267));
      qa.push_back(mk(0, 1, 0, 2, f0 + 277));
      ifa.keycode = START; step(1); ifa.keycode = 8'h00;
      step(4);
      chk("spawn0 not yet", ifa.note_active, 2'b00);
      step(1);
      chk("spawn0 active", ifa.note_active, 2'b01);
      chk("spawn0 y", ycur(0, 0), 100);
      step(10);
      chk("spawn1 active", ifa.note_active, 2'b11);
      chk("slot0 y after 10", ycur(0, 0), 110);
      chk("slot1 y at spawn", ycur(0, 1), 100);
      wait_done(0, 300);
      chk("done frame", fr, f0 + 278);
      chk("miss run hit_count", ifa.hit_count, 0);
      chk("miss run miss_count", ifa.miss_count, 2);

      // Restart keeps counts until the next start clears them
      ifa.keycode = RESTART; step(1); ifa.keycode = 8'h00;
      chk("restart lane_done", ifa.lane_done, 0);
      chk("restart miss_count held", ifa.miss_count, 2);
      ifa.keycode = START; step(1); ifa.keycode = 8'h00;
      chk("start clears miss_count", ifa.miss_count, 0);

      // Single press at Y=320 grades slot0, slot1 later misses
      wait_y(0, 0, 320, 400);
      g = fr;
      qa.push_back(mk(1, 0, 1, 0, g + 1));
      qa.push_back(mk(0, 1, 1, 1, -1));
      ifa.keycode = KEY; step(1); ifa.keycode = 8'h00;
      chk("hit retires slot0", ifa.note_active, 2'b10);
      wait_done(0, 400);
      chk("T3 hit_count", ifa.hit_count, 1);
      chk("T3 miss_count", ifa.miss_count, 1);

      // Hold from Y=299 (edge outside window): nothing graded until re-press
      restart_start_a();
      wait_y(0, 0, 299, 400);
      qa.push_back(mk(0, 1, 0, 1, -1));
      ifa.keycode_second = KEY;
      wait_active_a(2'b10, 200);
      ifa.keycode_second = 8'h00; step(1);
      g = fr;
      qa.push_back(mk(1, 0, 1, 1, g + 1));
      ifa.keycode = KEY; step(1); ifa.keycode = 8'h00;
      chk("re-press retires slot1", ifa.note_active, 2'b00);
      wait_done(0, 50);
      chk("T4a hit_count", ifa.hit_count, 1);
      chk("T4a miss_count", ifa.miss_count, 1);

      // Hold from Y=300 (edge in window): slot0 hit once, slot1 misses
      restart_start_a();
      wait_y(0, 0, 300, 400);
      g = fr;
      qa.push_back(mk(1, 0, 1, 0, g + 1));
      qa.push_back(mk(0, 1, 1, 1, -1));
      ifa.keycode = KEY;
      wait_done(0, 400);
      ifa.keycode = 8'h00;
      chk("T4b hit_count", ifa.hit_count, 1);
      chk("T4b miss_count", ifa.miss_count, 1);

      // Reset mid-run aborts with no pulses
      restart_start_a();
      wait_y(0, 0, 320, 400);
      g = fr;
      qa.push_back(mk(1, 0, 1, 0, g + 1));
      ifa.keycode = KEY; step(1); ifa.keycode = 8'h00;
      chk("pre-reset hit_count", ifa.hit_count, 1);
      chk("pre-reset slot1 live", ifa.note_active, 2'b10);
      Reset = 1'b1; step(1); Reset = 1'b0;
      chk("mid reset note_active", ifa.note_active, 0);
      chk("mid reset hit_count", ifa.hit_count, 0);
      chk("mid reset noteY", ifa.noteY, {10'd100, 10'd100});
      chk("mid reset lane_done", ifa.lane_done, 0);
      step(20);
      chk("stays idle", ifa.note_active, 0);
      chk("stays idle noteY", ifa.noteY, {10'd100, 10'd100});

      // Lane B: both in window, one press grades only slot0
      ifb.keycode = START; step(1); ifb.keycode = 8'h00;
      wait_y(1, 1, 310, 400);
      chk("B slot0 y", ycur(1, 0), 312);
      g = fr;
      qb.push_back(mk(1, 0, 1, 0, g + 1));
      ifb.keycode = KEY; step(1); ifb.keycode = 8'h00;
      chk("B first press slot0 only", ifb.note_active, 2'b10);
      step(1);
      g = fr;
      qb.push_back(mk(1, 0, 2, 0, g + 1));
      ifb.keycode = KEY; step(1); ifb.keycode = 8'h00;
      chk("B second press slot1", ifb.note_active, 2'b00);
      wait_done(1, 50);
      chk("B hit_count", ifb.hit_count, 2);
      chk("B miss_count", ifb.miss_count, 0);

      step(2);
      chk("A events drained", qa.size(), 0);
      chk("B events drained", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
